// File: rtl/demux8_pkg.sv
// Shared widths, FSM state type and select range check for the demux8_bank write-side lane bank.
package demux8_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_LANES = 8;
    localparam int unsigned SEL_W   = 5;

    typedef enum logic [0:0] {
        S_IDLE,
        S_CLEAR
    } state_t;

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(N_LANES);
    endfunction

endpackage

// File: rtl/sel_decoder.sv
// One-hot lane enable decode with an out-of-range flag; used for both writes and the clear sweep.
module sel_decoder
    import demux8_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [N_LANES-1:0] onehot,
    output logic               out_of_range
);

    always_comb begin
        onehot       = '0;
        out_of_range = 1'b0;
        if (en) begin
            if (in_range(sel)) begin
                onehot[sel[2:0]] = 1'b1;
            end else begin
                out_of_range = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_bank.sv
// Eight registered 32-bit lanes written by select, with valid bits and an 8-cycle clear sweep.
// Optional write-to-read forwarding is enabled by defining DEMUX8_BANK_BYPASS_EN.
module demux8_bank
    import demux8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               clr,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_hit,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [DATA_W-1:0]  out4,
    output logic [DATA_W-1:0]  out5,
    output logic [DATA_W-1:0]  out6,
    output logic [DATA_W-1:0]  out7,
    output logic [N_LANES-1:0] lane_valid,
    output logic               busy,
    output logic               err
);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   lane_q [N_LANES];
    logic [N_LANES-1:0]  valid_q;
    logic                err_q;

    logic [SEL_W-1:0]    dec_sel;
    logic                dec_en;
    logic [N_LANES-1:0]  dec_onehot;
    logic                dec_oor;

    // The decoder is steered to the sweep counter while clearing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ready = 1'b0;
        busy     = 1'b0;
        dec_sel  = wr_sel;
        dec_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                wr_ready = 1'b1;
                dec_en   = wr_valid;
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = 3'd0;
                end
            end
            S_CLEAR: begin
                busy    = 1'b1;
                dec_sel = {{(SEL_W-3){1'b0}}, cnt_q};
                dec_en  = 1'b1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    sel_decoder u_sel_decoder (
        .sel          (dec_sel),
        .en           (dec_en),
        .onehot       (dec_onehot),
        .out_of_range (dec_oor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            valid_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < N_LANES; i++) begin
                if (dec_onehot[i]) begin
                    lane_q[i]  <= (state_q == S_CLEAR) ? '0 : wr_data;
                    valid_q[i] <= (state_q == S_IDLE);
                end
            end
            if (state_q == S_IDLE && dec_oor) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (in_range(rd_sel)) begin
            rd_data = lane_q[rd_sel[2:0]];
            rd_hit  = valid_q[rd_sel[2:0]];
        end
`ifdef DEMUX8_BANK_BYPASS_EN
        if (wr_ready && wr_valid && in_range(wr_sel) && (wr_sel == rd_sel)) begin
            rd_data = wr_data;
            rd_hit  = 1'b1;
        end
`endif
    end

    assign out0       = lane_q[0];
    assign out1       = lane_q[1];
    assign out2       = lane_q[2];
    assign out3       = lane_q[3];
    assign out4       = lane_q[4];
    assign out5       = lane_q[5];
    assign out6       = lane_q[6];
    assign out7       = lane_q[7];
    assign lane_valid = valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_demux8_bank.sv
// Directed self-checking bench for demux8_bank; expected values are hand-computed constants.
module tb_demux8_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic        clr;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  lane_valid;
    logic        busy;
    logic        err;
    logic [31:0] outs [8];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    demux8_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .clr        (clr),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out5       (out5),
        .out6       (out6),
        .out7       (out7),
        .lane_valid (lane_valid),
        .busy       (busy),
        .err        (err)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks then sit mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        clr      = 1'b0;
        rd_sel   = '0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out0", out0, 32'h0);
        check_eq("rst_out7", out7, 32'h0);
        check_eq("rst_valid", {24'h0, lane_valid}, 32'h0);
        check_eq("rst_ready", {31'h0, wr_ready}, 32'h1);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_err", {31'h0, err}, 32'h0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_rd_hit", {31'h0, rd_hit}, 32'h0);

        // Three back-to-back writes
        wr_valid = 1'b1;
        wr_sel   = 5'd0;
        wr_data  = 32'h0000003F;
        step();
        check_eq("wr0_out0", out0, 32'h0000003F);
        check_eq("wr0_out7", out7, 32'h0);
        wr_sel  = 5'd7;
        wr_data = 32'h0011C03F;
        step();
        check_eq("wr7_out7", out7, 32'h0011C03F);
        check_eq("wr7_out2", out2, 32'h0);
        wr_sel  = 5'd2;
        wr_data = 32'h0C000039;
        step();
        wr_valid = 1'b0;
        check_eq("wr2_out2", out2, 32'h0C000039);
        check_eq("valid_85", {24'h0, lane_valid}, 32'h85);
        rd_sel = 5'd7;
        #1;
        check_eq("rd7_data", rd_data, 32'h0011C03F);
        check_eq("rd7_hit", {31'h0, rd_hit}, 32'h1);
        rd_sel = 5'd8;
        #1;
        check_eq("rd8_data", rd_data, 32'h0);
        check_eq("rd8_hit", {31'h0, rd_hit}, 32'h0);

        // Same-cycle write and read of lane 4
        wr_valid = 1'b1;
        wr_sel   = 5'd4;
        wr_data  = 32'h27;
        rd_sel   = 5'd4;
        #1;
`ifdef DEMUX8_BANK_BYPASS_EN
        check_eq("byp_rd_data", rd_data, 32'h27);
        check_eq("byp_rd_hit", {31'h0, rd_hit}, 32'h1);
`else
        check_eq("byp_rd_data", rd_data, 32'h0);
        check_eq("byp_rd_hit", {31'h0, rd_hit}, 32'h0);
`endif
        check_eq("byp_out4_old", out4, 32'h0);
        step();
        wr_valid = 1'b0;
        check_eq("byp_rd_next", rd_data, 32'h27);
        check_eq("byp_hit_next", {31'h0, rd_hit}, 32'h1);

        // Fill all lanes, then sweep with a write held pending
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 5'(i);
            wr_data  = 32'h100 + 32'(i);
            step();
        end
        wr_valid = 1'b0;
        check_eq("fill_valid", {24'h0, lane_valid}, 32'hFF);
        clr = 1'b1;
        step();
        clr      = 1'b0;
        wr_valid = 1'b1;
        wr_sel   = 5'd1;
        wr_data  = 32'hAAAA5555;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("sw%0d_busy", k), {31'h0, busy}, 32'h1);
            check_eq($sformatf("sw%0d_ready", k), {31'h0, wr_ready}, 32'h0);
            check_eq($sformatf("sw%0d_pre", k), outs[k], 32'h100 + 32'(k));
            clr = (k == 3);
            step();
            clr = 1'b0;
            check_eq($sformatf("sw%0d_lane", k), outs[k], 32'h0);
            check_eq($sformatf("sw%0d_vbit", k), {31'h0, lane_valid[k]}, 32'h0);
        end
        check_eq("sw_end_ready", {31'h0, wr_ready}, 32'h1);
        check_eq("sw_end_busy", {31'h0, busy}, 32'h0);
        check_eq("sw_end_out1", out1, 32'h0);
        step();
        wr_valid = 1'b0;
        check_eq("held_wr_out1", out1, 32'hAAAA5555);
        check_eq("held_wr_busy", {31'h0, busy}, 32'h0);

        // Out-of-range write select
        wr_valid = 1'b1;
        wr_sel   = 5'd9;
        wr_data  = 32'hDEADBEEF;
        #1;
        check_eq("oor_ready", {31'h0, wr_ready}, 32'h1);
        step();
        check_eq("oor_err", {31'h0, err}, 32'h1);
        check_eq("oor_valid", {24'h0, lane_valid}, 32'h02);
        check_eq("oor_out1", out1, 32'hAAAA5555);
        check_eq("oor_out0", out0, 32'h0);
        wr_sel  = 5'd5;
        wr_data = 32'h55;
        step();
        wr_valid = 1'b0;
        check_eq("good_out5", out5, 32'h55);
        check_eq("err_sticky", {31'h0, err}, 32'h1);

        // clr with a write to lane 3 in the same cycle
        wr_valid = 1'b1;
        wr_sel   = 5'd3;
        wr_data  = 32'h6000003F;
        clr      = 1'b1;
        step();
        wr_valid = 1'b0;
        clr      = 1'b0;
        check_eq("cw_out3", out3, 32'h6000003F);
        check_eq("cw_busy", {31'h0, busy}, 32'h1);
        step();
        step();
        step();
        check_eq("cw_out3_hold", out3, 32'h6000003F);
        step();
        check_eq("cw_out3_clr", out3, 32'h0);
        check_eq("cw_vbit3", {31'h0, lane_valid[3]}, 32'h0);
        check_eq("cw_out5_pre", out5, 32'h55);

        // Reset during sweep step 4
        rst    = 1'b1;
        rd_sel = 5'd5;
        step();
        rst = 1'b0;
        check_eq("rr_out5", out5, 32'h0);
        check_eq("rr_out1", out1, 32'h0);
        check_eq("rr_valid", {24'h0, lane_valid}, 32'h0);
        check_eq("rr_ready", {31'h0, wr_ready}, 32'h1);
        check_eq("rr_busy", {31'h0, busy}, 32'h0);
        check_eq("rr_err", {31'h0, err}, 32'h0);
        check_eq("rr_rd_data", rd_data, 32'h0);
        check_eq("rr_rd_hit", {31'h0, rd_hit}, 32'h0);

        wr_valid = 1'b1;
        wr_sel   = 5'd6;
        wr_data  = 32'h1234;
        step();
        wr_valid = 1'b0;
        check_eq("post_rst_out6", out6, 32'h1234);
        check_eq("post_rst_valid", {24'h0, lane_valid}, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
